// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - registered EX-stage ALU with start/busy/done handshake and shift-add multiply
// Optional feature: define ALU_DIV_EN to build the restoring unsigned divider (op 10); otherwise op 10 is illegal.

module alu_seq_muldiv #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   read_data1,
    input  logic [WIDTH-1:0]   read_data2,
    input  logic [3:0]         op_code,
    input  logic [SHAMT_W-1:0] shift_amt,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic               zero,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic               illegal_op
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opa;
    // acc_hi:acc_lo hold product high:low for mul, remainder:quotient for div
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] mul_add;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] alu_y;
    logic             alu_ill;

    assign mul_add = {WIDTH{acc_lo[0]}} & opa;
    assign mul_sum = {1'b0, acc_hi} + {1'b0, mul_add};

`ifdef ALU_DIV_EN
    logic [WIDTH-1:0] opb;
    logic             is_div;
    logic             dz_pend;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opb};
    assign div_ge   = (div_sh >= {1'b0, opb});
`else
    assign div_by_zero = 1'b0;
`endif

    // Single-cycle result for ops 0-8; flags every code with no datapath as illegal
    always_comb begin
        alu_y   = '0;
        alu_ill = 1'b0;
        case (op_code)
            4'd0:    alu_y = read_data1 + read_data2;
            4'd1:    alu_y = read_data1 - read_data2;
            4'd2:    alu_y = read_data1 & read_data2;
            4'd3:    alu_y = read_data1 | read_data2;
            4'd4:    alu_y = read_data1 << shift_amt;
            4'd5:    alu_y = read_data1 >> shift_amt;
            4'd6:    alu_y = WIDTH'($signed(read_data1) >>> shift_amt);
            4'd7:    alu_y = (read_data1 > read_data2) ? read_data1 : read_data2;
            4'd8:    alu_y = (read_data1 < read_data2) ? read_data1 : read_data2;
            4'd9:    alu_y = '0;
`ifdef ALU_DIV_EN
            4'd10:   alu_y = '0;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    // Control FSM plus datapath registers: accept in IDLE, iterate in RUN, publish on the final edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            opa        <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            result     <= '0;
            result_hi  <= '0;
            zero       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            illegal_op <= 1'b0;
`ifdef ALU_DIV_EN
            opb         <= '0;
            is_div      <= 1'b0;
            dz_pend     <= 1'b0;
            div_by_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        illegal_op <= 1'b0;
`ifdef ALU_DIV_EN
                        div_by_zero <= 1'b0;
`endif
                        if (op_code == 4'd9) begin
                            state  <= RUN;
                            busy   <= 1'b1;
                            cnt    <= '0;
                            opa    <= read_data1;
                            acc_hi <= '0;
                            acc_lo <= read_data2;
`ifdef ALU_DIV_EN
                            is_div  <= 1'b0;
                            dz_pend <= 1'b0;
                        end else if (op_code == 4'd10) begin
                            state  <= RUN;
                            busy   <= 1'b1;
                            is_div <= 1'b1;
                            opb    <= read_data2;
                            if (read_data2 == '0) begin
                                // Skip the iterations: preload the final answer and finish next edge
                                cnt     <= CNT_LAST;
                                dz_pend <= 1'b1;
                                acc_hi  <= read_data1;
                                acc_lo  <= '1;
                            end else begin
                                cnt     <= '0;
                                dz_pend <= 1'b0;
                                acc_hi  <= '0;
                                acc_lo  <= read_data1;
                            end
`endif
                        end else begin
                            result     <= alu_y;
                            result_hi  <= '0;
                            zero       <= (alu_y == '0);
                            illegal_op <= alu_ill;
                            done       <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= acc_lo;
                        result_hi <= acc_hi;
`ifdef ALU_DIV_EN
                        zero        <= is_div ? (acc_lo == '0) : ({acc_hi, acc_lo} == '0);
                        div_by_zero <= dz_pend;
`else
                        zero      <= ({acc_hi, acc_lo} == '0);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
`ifdef ALU_DIV_EN
                        if (is_div) begin
                            if (div_ge) begin
                                acc_hi <= div_diff[WIDTH-1:0];
                                acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                            end else begin
                                acc_hi <= div_sh[WIDTH-1:0];
                                acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end
`else
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// tb/tb_alu_seq_muldiv.sv - self-checking bench for alu_seq_muldiv at WIDTH=32 and WIDTH=8

module tb_alu_seq_muldiv;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        st32 = 1'b0;
    logic [31:0] a32  = '0;
    logic [31:0] b32  = '0;
    logic [3:0]  op32 = '0;
    logic [4:0]  sh32 = '0;
    logic [31:0] r32, rh32;
    logic        z32, bz32, d32, dz32, il32;

    logic        st8 = 1'b0;
    logic [7:0]  a8  = '0;
    logic [7:0]  b8  = '0;
    logic [3:0]  op8 = '0;
    logic [2:0]  sh8 = '0;
    logic [7:0]  r8, rh8;
    logic        z8, bz8, d8, dz8, il8;

    alu_seq_muldiv #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(st32), .read_data1(a32), .read_data2(b32),
        .op_code(op32), .shift_amt(sh32), .result(r32), .result_hi(rh32), .zero(z32),
        .busy(bz32), .done(d32), .div_by_zero(dz32), .illegal_op(il32)
    );

    alu_seq_muldiv #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .read_data1(a8), .read_data2(b8),
        .op_code(op8), .shift_amt(sh8), .result(r8), .result_hi(rh8), .zero(z8),
        .busy(bz8), .done(d8), .div_by_zero(dz8), .illegal_op(il8)
    );

    typedef struct packed {
        logic [63:0] res;
        logic [63:0] hi;
        logic        zero;
        logic        ill;
        logic        dz;
        logic [7:0]  lat;
    } exp_t;

    // Outcome of one operation from plain arithmetic; lat = edges after acceptance until done is registered
    function automatic exp_t model_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                      input int sh, input int w);
        logic [63:0] mask;
        logic [63:0] p;
        exp_t e;
        mask = (64'd1 << w) - 64'd1;
        e = '0;
        case (op)
            4'd0: e.res = (a + b) & mask;
            4'd1: e.res = (a - b) & mask;
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = (a << sh) & mask;
            4'd5: e.res = a >> sh;
            4'd6: begin
                e.res = a >> sh;
                if (a[w-1]) e.res = e.res | (mask & ~(mask >> sh));
            end
            4'd7: e.res = (a > b) ? a : b;
            4'd8: e.res = (a < b) ? a : b;
            4'd9: begin
                p = a * b;
                e.res = p & mask;
                e.hi  = (p >> w) & mask;
                e.lat = 8'(w + 1);
            end
`ifdef ALU_DIV_EN
            4'd10: begin
                if (b == 64'd0) begin
                    e.res = mask;
                    e.hi  = a;
                    e.dz  = 1'b1;
                    e.lat = 8'd1;
                end else begin
                    e.res = a / b;
                    e.hi  = a % b;
                    e.lat = 8'(w + 1);
                end
            end
`endif
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 64'd0) && (op != 4'd9 || e.hi == 64'd0);
        return e;
    endfunction

    logic        in_start [2];
    logic [63:0] in_a [2];
    logic [63:0] in_b [2];
    logic [3:0]  in_op [2];
    logic [7:0]  in_sh [2];
    assign in_start[0] = st32;         assign in_start[1] = st8;
    assign in_a[0] = {32'b0, a32};     assign in_a[1] = {56'b0, a8};
    assign in_b[0] = {32'b0, b32};     assign in_b[1] = {56'b0, b8};
    assign in_op[0] = op32;            assign in_op[1] = op8;
    assign in_sh[0] = {3'b0, sh32};    assign in_sh[1] = {5'b0, sh8};

    logic [63:0] act_res [2];
    logic [63:0] act_hi [2];
    logic        act_zero [2], act_busy [2], act_done [2], act_dz [2], act_ill [2];
    assign act_res[0] = {32'b0, r32};  assign act_res[1] = {56'b0, r8};
    assign act_hi[0]  = {32'b0, rh32}; assign act_hi[1]  = {56'b0, rh8};
    assign act_zero[0] = z32;  assign act_zero[1] = z8;
    assign act_busy[0] = bz32; assign act_busy[1] = bz8;
    assign act_done[0] = d32;  assign act_done[1] = d8;
    assign act_dz[0]   = dz32; assign act_dz[1]   = dz8;
    assign act_ill[0]  = il32; assign act_ill[1]  = il8;

    exp_t        pend [2];
    int          rc [2];
    logic [63:0] m_res [2];
    logic [63:0] m_hi [2];
    logic        m_zero [2], m_busy [2], m_done [2], m_dz [2], m_ill [2];

    // Transaction-level model: accept when idle, count down the latency, then publish the pending outcome
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                pend[i] <= '0; rc[i] <= 0;
                m_res[i] <= '0; m_hi[i] <= '0; m_zero[i] <= 1'b0; m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0; m_dz[i] <= 1'b0; m_ill[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                exp_t e;
                m_done[i] <= 1'b0;
                if (rc[i] != 0) begin
                    rc[i] <= rc[i] - 1;
                    if (rc[i] == 1) begin
                        m_busy[i] <= 1'b0;
                        m_done[i] <= 1'b1;
                        m_res[i]  <= pend[i].res;
                        m_hi[i]   <= pend[i].hi;
                        m_zero[i] <= pend[i].zero;
                        m_dz[i]   <= pend[i].dz;
                    end
                end else if (in_start[i]) begin
                    e = model_op(in_op[i], in_a[i], in_b[i], int'(in_sh[i]), (i == 0) ? 32 : 8);
                    m_ill[i] <= e.ill;
                    m_dz[i]  <= 1'b0;
                    if (e.lat != 8'd0) begin
                        pend[i]   <= e;
                        rc[i]     <= int'(e.lat);
                        m_busy[i] <= 1'b1;
                    end else begin
                        m_res[i]  <= e.res;
                        m_hi[i]   <= e.hi;
                        m_zero[i] <= e.zero;
                        m_done[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Every cycle, both DUTs against the model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({act_res[i], act_hi[i], act_zero[i], act_busy[i], act_done[i], act_dz[i], act_ill[i]} !==
                {m_res[i], m_hi[i], m_zero[i], m_busy[i], m_done[i], m_dz[i], m_ill[i]}) begin
                failures++;
                $display("FAIL model_w%0d t=%0t got res=%h hi=%h z=%b busy=%b done=%b dz=%b ill=%b exp res=%h hi=%h z=%b busy=%b done=%b dz=%b ill=%b",
                         (i == 0) ? 32 : 8, $time, act_res[i], act_hi[i], act_zero[i], act_busy[i], act_done[i],
                         act_dz[i], act_ill[i], m_res[i], m_hi[i], m_zero[i], m_busy[i], m_done[i], m_dz[i], m_ill[i]);
            end
        end
    end

    task automatic lit(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic issue(input int sel, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int sh);
        if (sel == 0) begin
            st32 = 1'b1; op32 = op; a32 = a; b32 = b; sh32 = 5'(sh);
        end else begin
            st8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; sh8 = 3'(sh);
        end
    endtask

    task automatic wait_done(input int sel, output int n);
        n = 0;
        while (!act_done[sel] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Start an op just before edge E0, release start after it, report edges after E0 until done is seen
    task automatic run_op(input int sel, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int sh, output int n);
        @(negedge clk);
        issue(sel, op, a, b, sh);
        @(posedge clk); #1;
        if (sel == 0) st32 = 1'b0; else st8 = 1'b0;
        wait_done(sel, n);
    endtask

    initial begin
        int n;
        int pulses;
        repeat (2) @(posedge clk);
        #1;
        lit("reset_result", act_res[0], 64'd0);
        lit("reset_busy", {63'd0, act_busy[0]}, 64'd0);
        lit("reset_done", {63'd0, act_done[0]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 4'd1, 32'd2, 32'd2, 0, n);
        lit("sub_latency", 64'(n), 64'd0);
        lit("sub_result", act_res[0], 64'd0);
        lit("sub_zero", {63'd0, act_zero[0]}, 64'd1);
        lit("sub_busy", {63'd0, act_busy[0]}, 64'd0);

        @(negedge clk);
        issue(0, 4'd0, 32'd2, 32'd3, 0);
        @(posedge clk); #1;
        lit("b2b_add_done", {63'd0, act_done[0]}, 64'd1);
        lit("b2b_add_result", act_res[0], 64'd5);
        op32 = 4'd7; a32 = 32'd1; b32 = 32'd3;
        @(posedge clk); #1;
        lit("b2b_max_done", {63'd0, act_done[0]}, 64'd1);
        lit("b2b_max_result", act_res[0], 64'd3);
        st32 = 1'b0;

        @(negedge clk);
        issue(0, 4'd9, 32'hFFFF_FFFF, 32'd2, 0);
        @(posedge clk); #1;
        st32 = 1'b0;
        n = 0;
        while (!act_done[0] && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 5) begin st32 = 1'b1; op32 = 4'd0; a32 = 32'd1; b32 = 32'd1; end
            if (n == 7) st32 = 1'b0;
            if (n == 10) lit("mul_busy_mid", {63'd0, act_busy[0]}, 64'd1);
        end
        lit("mul_latency", 64'(n), 64'd33);
        lit("mul_result", act_res[0], 64'hFFFF_FFFE);
        lit("mul_result_hi", act_hi[0], 64'd1);
        lit("mul_zero", {63'd0, act_zero[0]}, 64'd0);
        lit("mul_busy_end", {63'd0, act_busy[0]}, 64'd0);

        run_op(0, 4'd5, 32'h8000_0000, 32'd0, 4, n);
        lit("srl_result", act_res[0], 64'h0800_0000);
        run_op(0, 4'd6, 32'h8000_0000, 32'd0, 4, n);
        lit("sra_result", act_res[0], 64'hF800_0000);

        @(negedge clk);
        issue(0, 4'd9, 32'd5, 32'd7, 0);
        @(posedge clk); #1;
        st32 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        lit("rst_mid_result", act_res[0], 64'd0);
        lit("rst_mid_busy", {63'd0, act_busy[0]}, 64'd0);
        lit("rst_mid_done", {63'd0, act_done[0]}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (act_done[0]) pulses++;
        end
        lit("rst_mid_no_done", 64'(pulses), 64'd0);

        run_op(0, 4'd13, 32'd12, 32'd34, 0, n);
        lit("illegal_latency", 64'(n), 64'd0);
        lit("illegal_flag", {63'd0, act_ill[0]}, 64'd1);
        lit("illegal_result", act_res[0], 64'd0);
        lit("illegal_zero", {63'd0, act_zero[0]}, 64'd1);
        run_op(0, 4'd8, 32'd9, 32'd4, 0, n);
        lit("min_result", act_res[0], 64'd4);
        lit("illegal_cleared", {63'd0, act_ill[0]}, 64'd0);

`ifdef ALU_DIV_EN
        run_op(0, 4'd10, 32'd100, 32'd7, 0, n);
        lit("div_latency", 64'(n), 64'd33);
        lit("div_quotient", act_res[0], 64'd14);
        lit("div_remainder", act_hi[0], 64'd2);
        run_op(0, 4'd10, 32'd9, 32'd0, 0, n);
        lit("div0_latency", 64'(n), 64'd1);
        lit("div0_result", act_res[0], 64'hFFFF_FFFF);
        lit("div0_result_hi", act_hi[0], 64'd9);
        lit("div0_flag", {63'd0, act_dz[0]}, 64'd1);
        run_op(1, 4'd10, 32'd200, 32'd7, 0, n);
        lit("w8_div_latency", 64'(n), 64'd9);
        lit("w8_div_quotient", act_res[1], 64'd28);
        lit("w8_div_remainder", act_hi[1], 64'd4);
`else
        run_op(0, 4'd10, 32'd100, 32'd7, 0, n);
        lit("nodiv_latency", 64'(n), 64'd0);
        lit("nodiv_illegal", {63'd0, act_ill[0]}, 64'd1);
        lit("nodiv_result", act_res[0], 64'd0);
        run_op(1, 4'd10, 32'd100, 32'd7, 0, n);
        lit("w8_nodiv_illegal", {63'd0, act_ill[1]}, 64'd1);
        lit("w8_nodiv_dz", {63'd0, act_dz[1]}, 64'd0);
`endif

        run_op(1, 4'd9, 32'hFF, 32'hFF, 0, n);
        lit("w8_mul_latency", 64'(n), 64'd9);
        lit("w8_mul_result", act_res[1], 64'h01);
        lit("w8_mul_result_hi", act_hi[1], 64'hFE);
        run_op(1, 4'd9, 32'h10, 32'h10, 0, n);
        lit("w8_mul_lowzero_result", act_res[1], 64'h00);
        lit("w8_mul_lowzero_zero", {63'd0, act_zero[1]}, 64'd0);
        run_op(1, 4'd9, 32'h00, 32'h35, 0, n);
        lit("w8_mul_zero", {63'd0, act_zero[1]}, 64'd1);
        run_op(1, 4'd6, 32'h90, 32'd0, 3, n);
        lit("w8_sra_result", act_res[1], 64'hF2);
        run_op(1, 4'd0, 32'hF0, 32'h20, 0, n);
        lit("w8_add_wrap", act_res[1], 64'h10);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
